brkill_queue_v2: RTL

- Parametrised circular FIFO for LSU micro-ops. Each entry carries a branch mask and a flushable flag.
- Entries are killed in place by branch mispredicts or pipeline flush.
- Killed entries at the head are reclaimed automatically, without blocking, one per cycle.
- Sits between the LSU request path and the data-cache pipeline. Generalises the earlier branch-killable queue to any depth, payload width and branch-mask width, and adds an optional flow-through mode.

---
 rtl/brkill_queue_v2.sv | 117 +++++++++++
 1 files changed

// File: rtl/brkill_queue_v2.sv
// Circular LSU micro-op queue whose entries are killed in place by branch
// mispredicts or flush; dead entries at the head are reclaimed one per cycle.
module brkill_queue_v2 #(
  parameter int ENTRIES = 16,
  parameter int DATA_W  = 64,
  parameter int BR_W    = 16,
  parameter bit FLOW    = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enq_valid,
  output logic                           enq_ready,
  input  logic [DATA_W-1:0]              enq_data,
  input  logic [BR_W-1:0]                enq_br_mask,
  input  logic                           enq_flushable,
  output logic                           deq_valid,
  input  logic                           deq_ready,
  output logic [DATA_W-1:0]              deq_data,
  output logic [BR_W-1:0]                deq_br_mask,
  input  logic [BR_W-1:0]                br_resolve_mask,
  input  logic [BR_W-1:0]                br_mispredict_mask,
  input  logic                           flush,
  output logic                           empty,
  output logic [$clog2(ENTRIES+1)-1:0]   count
);
  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES+1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(ENTRIES-1);

  logic [PTR_W-1:0]  enq_ptr, deq_ptr;
  logic              maybe_full;
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] fl_q;
  logic [BR_W-1:0]   mask_q [ENTRIES];
  logic [DATA_W-1:0] data_q [ENTRIES];

  logic ptr_match, full, head_valid, head_kill, enq_kill, flow_path;
  logic enq_fire, do_write, pop;

  function automatic logic kill_f(input logic [BR_W-1:0] mask, input logic fl,
                                  input logic [BR_W-1:0] mis, input logic fls);
    return ((mask & mis) != '0) | (fls & fl);
  endfunction

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign ptr_match  = (enq_ptr == deq_ptr);
  assign full       = ptr_match & maybe_full;
  assign empty      = ptr_match & ~maybe_full;
  assign head_valid = valid_q[deq_ptr];
  assign head_kill  = kill_f(mask_q[deq_ptr], fl_q[deq_ptr], br_mispredict_mask, flush);
  assign enq_kill   = kill_f(enq_br_mask, enq_flushable, br_mispredict_mask, flush);
  assign flow_path  = FLOW & empty;

  assign enq_ready  = ~full;
  assign enq_fire   = enq_valid & ~full;
  // A bypassed item is either consumed this cycle or dropped because it died.
  assign do_write   = enq_fire & ~(flow_path & (deq_ready | enq_kill));
  // Live head leaves on handshake; a dead head is reclaimed without waiting.
  assign pop        = ~empty & ((head_valid & ~head_kill & deq_ready) | ~head_valid);

  always_comb begin
    if (flow_path) begin
      deq_valid   = enq_valid & ~enq_kill;
      deq_data    = enq_data;
      deq_br_mask = enq_br_mask & ~br_resolve_mask;
    end else begin
      deq_valid   = ~empty & head_valid & ~head_kill;
      deq_data    = data_q[deq_ptr];
      deq_br_mask = mask_q[deq_ptr] & ~br_resolve_mask;
    end
  end

  always_comb begin
    if (full)
      count = CNT_W'(ENTRIES);
    else if (enq_ptr >= deq_ptr)
      count = CNT_W'(enq_ptr - deq_ptr);
    else
      count = CNT_W'(ENTRIES) - CNT_W'(deq_ptr) + CNT_W'(enq_ptr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
      valid_q    <= '0;
      fl_q       <= '0;
      for (int i = 0; i < ENTRIES; i++) mask_q[i] <= '0;
    end else begin
      if (do_write) enq_ptr <= wrap_inc(enq_ptr);
      if (pop)      deq_ptr <= wrap_inc(deq_ptr);
      if (do_write != pop) maybe_full <= do_write;
      for (int i = 0; i < ENTRIES; i++) begin
        if (do_write && enq_ptr == PTR_W'(i)) begin
          valid_q[i] <= ~enq_kill;
          mask_q[i]  <= enq_br_mask & ~br_resolve_mask;
          fl_q[i]    <= enq_flushable;
        end else begin
          valid_q[i] <= valid_q[i] & ~(pop && deq_ptr == PTR_W'(i))
                        & ~kill_f(mask_q[i], fl_q[i], br_mispredict_mask, flush);
          mask_q[i]  <= mask_q[i] & ~br_resolve_mask;
        end
      end
    end
  end

  // Payload storage carries no reset; it is only observed behind valid.
  always_ff @(posedge clock) begin
    if (do_write) data_q[enq_ptr] <= enq_data;
  end

endmodule
